// File: rtl/sha_256_pkg.sv
// SHA-256 constants, round helper functions and shared types for the streaming core.
// Purely declarative; no state.
package sha_256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // H0 in the top word, matching the digest output layout.
    localparam logic [255:0] IV_PACKED = {IV[0], IV[1], IV[2], IV[3],
                                          IV[4], IV[5], IV[6], IV[7]};

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_256_round.sv
// One combinational SHA-256 compression round; chained R times per clock by the top.
module sha_256_round
    import sha_256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] kt_i,
    input  logic [31:0] wt_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    word_t t1;
    word_t t2;

    assign t1  = h_i + bsig1(e_i) + ch(e_i, f_i, g_i) + kt_i + wt_i;
    assign t2  = bsig0(a_i) + maj(a_i, b_i, c_i);

    assign a_o = t1 + t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;

endmodule

// File: rtl/sha_256_stream.sv
// Streaming multi-block SHA-256: digest valid 64/R+1 edges after the last block is accepted.
// in_ready only in IDLE; a pending digest holds the core in DONE until hash_ready.
module sha_256_stream
    import sha_256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int BLK_CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [511:0]         in_block,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [255:0]         hash,
    output logic                 hash_valid,
    input  logic                 hash_ready,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    localparam int         R      = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_T = 6'(64 - R);

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
            $error("sha_256_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [5:0]           t_q, t_d;
    word_t                w_q [16];
    word_t                w_d [16];
    logic [255:0]         work_q, work_d;
    logic [255:0]         h_q, h_d;
    logic [255:0]         hash_q, hash_d;
    logic                 hash_valid_q, hash_valid_d;
    logic                 last_q, last_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    logic [255:0]         chain [R+1];
    word_t                w_ext [16+R];
    logic [255:0]         h_sum;

    // Schedule words beyond the window feed on each other, so they are built in order.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = w_q[i];
        end
        for (int k = 0; k < R; k++) begin
            w_ext[16+k] = ssig1(w_ext[14+k]) + w_ext[9+k] + ssig0(w_ext[1+k]) + w_ext[k];
        end
    end

    assign chain[0] = work_q;

    generate
        for (genvar j = 0; j < R; j++) begin : g_round
            word_t na, nb, nc, nd, ne, nf, ng, nh;

            sha_256_round u_round (
                .a_i  (chain[j][255:224]),
                .b_i  (chain[j][223:192]),
                .c_i  (chain[j][191:160]),
                .d_i  (chain[j][159:128]),
                .e_i  (chain[j][127:96]),
                .f_i  (chain[j][95:64]),
                .g_i  (chain[j][63:32]),
                .h_i  (chain[j][31:0]),
                .kt_i (K[t_q + 6'(j)]),
                .wt_i (w_q[j]),
                .a_o  (na),
                .b_o  (nb),
                .c_o  (nc),
                .d_o  (nd),
                .e_o  (ne),
                .f_o  (nf),
                .g_o  (ng),
                .h_o  (nh)
            );

            assign chain[j+1] = {na, nb, nc, nd, ne, nf, ng, nh};
        end
    endgenerate

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[255-32*i -: 32] = h_q[255-32*i -: 32] + work_q[255-32*i -: 32];
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign hash       = hash_q;
    assign hash_valid = hash_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign blk_cnt    = blk_cnt_q;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        w_d          = w_q;
        work_d       = work_q;
        h_d          = h_q;
        hash_d       = hash_q;
        hash_valid_d = hash_valid_q;
        last_d       = last_q;
        blk_cnt_d    = blk_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = in_block[511-32*i -: 32];
                    end
                    // A new message restarts the chain from IV regardless of leftover H.
                    if (in_first) begin
                        work_d    = IV_PACKED;
                        h_d       = IV_PACKED;
                        blk_cnt_d = BLK_CNT_W'(1);
                    end else begin
                        work_d    = h_q;
                        blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                    end
                    last_d  = in_last;
                    t_d     = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = chain[R];
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = w_ext[i+R];
                end
                t_d = t_q + 6'(R);
                if (t_q == LAST_T) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                h_d = h_sum;
                if (last_q) begin
                    hash_d       = h_sum;
                    hash_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (hash_ready) begin
                    hash_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            t_q          <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            work_q       <= '0;
            h_q          <= IV_PACKED;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            last_q       <= 1'b0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            w_q          <= w_d;
            work_q       <= work_d;
            h_q          <= h_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
            last_q       <= last_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

endmodule
